// File: rtl/uart_rx_ext_if.sv
// Receive-side stream between uart_rx_ext and its consumer: FIFO head entry plus valid/ready.
// The receiver drives the head through the master modport; the consumer uses slave.
interface uart_rx_ext_if #(
    parameter int NUM_DATA_BITS = 8
);
    logic [NUM_DATA_BITS-1:0] o_data;
    logic                     o_parity_err;
    logic                     o_frame_err;
    logic                     o_break;
    logic                     o_valid;
    logic                     i_ready;

    modport master (
        output o_data, o_parity_err, o_frame_err, o_break, o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data, o_parity_err, o_frame_err, o_break, o_valid,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Runtime-configurable UART receiver: oversampled 3-sample majority voting, optional parity,
// 1/2 stop bits, framing and break detection, feeding a small first-word-fall-through FIFO.
module uart_rx_ext #(
    parameter int OVERSAMPLE_RATE = 16,
    parameter int NUM_DATA_BITS   = 8,
    parameter int DIV_W           = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic             i_parity_on,
    input  logic             i_parity_odd,
    input  logic             i_two_stop,
    uart_rx_ext_if.master    rx_if,
    output logic             o_overrun,
    output logic             o_busy
);
    localparam int KW = $clog2(OVERSAMPLE_RATE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(NUM_DATA_BITS + 1);
    localparam int EW = NUM_DATA_BITS + 3;

    localparam logic [KW-1:0] K_LO      = KW'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [KW-1:0] K_MID     = KW'(OVERSAMPLE_RATE / 2);
    localparam logic [KW-1:0] K_HI      = KW'(OVERSAMPLE_RATE / 2 + 1);
    localparam logic [KW-1:0] K_LAST    = KW'(OVERSAMPLE_RATE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(NUM_DATA_BITS);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    // Synchronizer resets to the idle level so release of reset never looks like a start bit.
    logic [2:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_reg <= 3'b111;
        else          sync_reg <= {sync_reg[1:0], i_rx};
    end

    assign rx_s = sync_reg[2];

    state_t                   state_reg,     state_next;
    logic [DIV_W-1:0]         div_cnt_reg,   div_cnt_next;
    logic [DIV_W-1:0]         div_lat_reg,   div_lat_next;
    logic [KW-1:0]            k_reg,         k_next;
    logic [1:0]               samp_reg,      samp_next;
    logic [NUM_DATA_BITS-1:0] shift_reg,     shift_next;
    logic [BW-1:0]            bit_cnt_reg,   bit_cnt_next;
    logic                     stop_cnt_reg,  stop_cnt_next;
    logic                     perr_reg,      perr_next;
    logic                     ferr_reg,      ferr_next;
    logic                     zero_reg,      zero_next;
    logic                     par_on_reg,    par_on_next;
    logic                     par_odd_reg,   par_odd_next;
    logic                     two_stop_reg,  two_stop_next;

    logic          tick, decide, bit_end, vote;
    logic          push;
    logic [EW-1:0] push_entry;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            div_lat_reg  <= '0;
            k_reg        <= '0;
            samp_reg     <= 2'b11;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            zero_reg     <= 1'b0;
            par_on_reg   <= 1'b0;
            par_odd_reg  <= 1'b0;
            two_stop_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            div_lat_reg  <= div_lat_next;
            k_reg        <= k_next;
            samp_reg     <= samp_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            zero_reg     <= zero_next;
            par_on_reg   <= par_on_next;
            par_odd_reg  <= par_odd_next;
            two_stop_reg <= two_stop_next;
        end
    end

    assign tick    = (state_reg != IDLE) && (div_cnt_reg == div_lat_reg);
    assign decide  = tick && (k_reg == K_HI);
    assign bit_end = tick && (k_reg == K_LAST);
    assign vote    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        div_lat_next  = div_lat_reg;
        k_next        = k_reg;
        samp_next     = samp_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        zero_next     = zero_reg;
        par_on_next   = par_on_reg;
        par_odd_next  = par_odd_reg;
        two_stop_next = two_stop_reg;
        push          = 1'b0;
        push_entry    = '0;

        if (tick) begin
            div_cnt_next = '0;
            k_next       = k_reg + 1'b1;
        end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
        end
        if (tick && (k_reg == K_LO))  samp_next[0] = rx_s;
        if (tick && (k_reg == K_MID)) samp_next[1] = rx_s;

        case (state_reg)
            IDLE: begin
                div_cnt_next = '0;
                k_next       = '0;
                if (!rx_s) begin
                    state_next    = START;
                    div_lat_next  = i_baud_div;
                    par_on_next   = i_parity_on;
                    par_odd_next  = i_parity_odd;
                    two_stop_next = i_two_stop;
                    shift_next    = '0;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    perr_next     = 1'b0;
                    ferr_next     = 1'b0;
                    zero_next     = 1'b1;
                end
            end
            START: begin
                if (decide && vote) state_next = IDLE;
                else if (bit_end)   state_next = DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_next   = {vote, shift_reg[NUM_DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (vote) zero_next = 1'b0;
                end
                if (bit_end && (bit_cnt_reg == BITS_LAST))
                    state_next = par_on_reg ? PARITY : STOP;
            end
            PARITY: begin
                if (decide) begin
                    perr_next = ((^shift_reg) ^ vote) != par_odd_reg;
                    if (vote) zero_next = 1'b0;
                end
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (decide) begin
                    ferr_next = ferr_reg | ~vote;
                    zero_next = zero_reg & ~vote;
                    if (stop_cnt_reg == two_stop_reg) begin
                        // Leave mid-bit so the next start edge is caught as early as possible.
                        push = 1'b1;
                        if (zero_reg && !vote) begin
                            push_entry = {1'b1, 1'b1, 1'b0, {NUM_DATA_BITS{1'b0}}};
                            state_next = BRK_WAIT;
                        end else begin
                            push_entry = {1'b0, ferr_reg | ~vote, perr_reg, shift_reg};
                            state_next = IDLE;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state_reg != IDLE);

    // Receive FIFO: storage is left unreset; the head is masked to zero while empty.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overrun_reg;
    logic          full, valid, pop, wr_en;
    logic [EW-1:0] head;

    assign full  = (count_reg == FIFO_FULL);
    assign valid = (count_reg != '0);
    assign pop   = valid && rx_if.i_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
            else if (!wr_en && pop) count_reg <= count_reg - 1'b1;
            overrun_reg <= push && full && !pop;
        end
    end

    assign head               = mem[rd_ptr_reg];
    assign o_overrun          = overrun_reg;
    assign rx_if.o_valid      = valid;
    assign rx_if.o_data       = valid ? head[NUM_DATA_BITS-1:0] : '0;
    assign rx_if.o_parity_err = valid & head[EW-3];
    assign rx_if.o_frame_err  = valid & head[EW-2];
    assign rx_if.o_break      = valid & head[EW-1];
endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: drives serial frames bit by bit and checks popped entries
// ({brk, ferr, perr, data}) against hand-computed values.
module tb_uart_rx_ext;
    localparam int DIV = 1;
    localparam int BIT = 16 * (DIV + 1);

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] baud_div;
    logic        parity_on, parity_odd, two_stop;
    logic        overrun, busy;

    uart_rx_ext_if #(.NUM_DATA_BITS(8)) rx_if ();

    uart_rx_ext #(
        .OVERSAMPLE_RATE(16),
        .NUM_DATA_BITS  (8),
        .DIV_W          (16),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .i_baud_div  (baud_div),
        .i_parity_on (parity_on),
        .i_parity_odd(parity_odd),
        .i_two_stop  (two_stop),
        .rx_if       (rx_if),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] q[$];
    int          valid_cycles;
    int          ovr_cnt;
    bit          busy_seen;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_if.o_valid) valid_cycles++;
            if (rx_if.o_valid && rx_if.i_ready)
                q.push_back({rx_if.o_break, rx_if.o_frame_err, rx_if.o_parity_err, rx_if.o_data});
            if (overrun) ovr_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                              input int nstop, input logic [1:0] stopv);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        for (int i = 0; i < nstop; i++) send_bit(stopv[i]);
        rx = 1'b1;
    endtask

    task automatic wait_entries(input string tag, input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check_eq(tag, q.size(), n);
    endtask

    task automatic pop_check(input string tag, input logic [10:0] exp);
        logic [10:0] e;
        e = 11'h7ff;
        if (q.size() > 0) e = q.pop_front();
        check_eq(tag, e, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        rx           = 1'b1;
        baud_div     = 16'(DIV);
        parity_on    = 1'b0;
        parity_odd   = 1'b0;
        two_stop     = 1'b0;
        rx_if.i_ready = 1'b1;
        valid_cycles = 0;
        ovr_cnt      = 0;
        busy_seen    = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_data", rx_if.o_data, 0);
        check_eq("rst_flags", {rx_if.o_break, rx_if.o_frame_err, rx_if.o_parity_err}, 0);
        check_eq("rst_valid", rx_if.o_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(10);

        // 8N1 0xA5, consumer always ready
        valid_cycles = 0;
        send_frame(8'hA5, 0, 0, 1, 2'b01);
        wait_entries("a5_count", 1, 4 * BIT);
        pop_check("a5_entry", 11'h0A5);
        check_eq("a5_valid_cycles", valid_cycles, 1);
        check_eq("a5_busy_after", busy, 0);

        // Odd parity: 0x3C has four ones, so a parity bit of 1 is correct and 0 is wrong.
        parity_on  = 1'b1;
        parity_odd = 1'b1;
        send_frame(8'h3C, 1, 0, 1, 2'b01);
        wait_entries("par_bad_count", 1, 4 * BIT);
        pop_check("par_bad_entry", 11'h13C);
        idle(BIT);
        send_frame(8'h3C, 1, 1, 1, 2'b01);
        wait_entries("par_good_count", 1, 4 * BIT);
        pop_check("par_good_entry", 11'h03C);
        parity_on  = 1'b0;
        parity_odd = 1'b0;
        idle(BIT);

        // Start-bit glitch: 4 clocks low is rejected by the start-bit vote
        busy_seen = 1'b0;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(60);
        check_eq("glitch_busy_seen", busy_seen, 1);
        check_eq("glitch_busy_back", busy, 0);
        check_eq("glitch_no_entry", q.size(), 0);
        send_frame(8'h55, 0, 0, 1, 2'b01);
        wait_entries("after_glitch_count", 1, 4 * BIT);
        pop_check("after_glitch_entry", 11'h055);
        idle(BIT);

        // Overrun: five frames into a four-entry FIFO with the consumer stalled
        rx_if.i_ready = 1'b0;
        ovr_cnt = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 1, 2'b01);
        idle(2 * BIT);
        check_eq("ovr_pulses", ovr_cnt, 1);
        check_eq("ovr_valid_full", rx_if.o_valid, 1);
        rx_if.i_ready = 1'b1;
        wait_entries("ovr_drain_count", 4, 20);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_drain_%0d", i), 11'(i));
        check_eq("ovr_drained_valid", rx_if.o_valid, 0);
        idle(BIT);

        // Two stop bits, second one low: framing error without break
        two_stop = 1'b1;
        send_frame(8'h7E, 0, 0, 2, 2'b01);
        idle(2 * BIT);
        wait_entries("ferr_count", 1, 4 * BIT);
        pop_check("ferr_entry", 11'h27E);

        // Line held low for three frame times: exactly one break entry
        rx = 1'b0;
        idle(33 * BIT);
        check_eq("brk_count", q.size(), 1);
        pop_check("brk_entry", 11'h600);
        check_eq("brk_busy_low", busy, 1);
        rx = 1'b1;
        idle(2 * BIT);
        check_eq("brk_no_more", q.size(), 0);
        check_eq("brk_busy_idle", busy, 0);
        send_frame(8'h42, 0, 0, 2, 2'b11);
        wait_entries("post_brk_count", 1, 4 * BIT);
        pop_check("post_brk_entry", 11'h042);
        two_stop = 1'b0;
        idle(BIT);

        // Reset in the middle of data bit 3 discards the partial frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        idle(BIT / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", busy, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2 * BIT);
        check_eq("midrst_no_entry", q.size(), 0);
        check_eq("midrst_valid", rx_if.o_valid, 0);
        send_frame(8'h96, 0, 0, 1, 2'b01);
        wait_entries("midrst_count", 1, 4 * BIT);
        pop_check("midrst_entry", 11'h096);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
